display_placar: RTL and testbench
=================================

DISPLAY_PLACAR -- requirements
Module: display_placar

Interface
- REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles per displayed digit in the multiplex scan (legal range 2 to 2^20).
- REQ-002 SHALL have port clock, input, 1 bit: single system clock; all state changes on its rising edge.
- REQ-003 SHALL have port clr, input, 1 bit: reset, asynchronous, active-low.
- REQ-004 SHALL have port somaTime, input, 7 bits: unsigned team score from the score register, 0 to 127.
- REQ-005 SHALL have port bcd, output, 12 bits: registered BCD of the last converted score; [11:8] hundreds, [7:4] tens, [3:0] units.
- REQ-006 SHALL have port pronto, output, 1 bit: one-cycle pulse when bcd updates.
- REQ-007 SHALL have port an, output, 3 bits: active-low digit enables; an[0] units, an[1] tens, an[2] hundreds.
- REQ-008 SHALL have port seg, output, 7 bits: active-low segments; seg[0]=a through seg[6]=g.

Function
- REQ-009 SHALL keep register ultimo (7 bits) holding the last value taken for conversion.
- REQ-010 SHALL use FSM states OCIOSO, CONVERTE, FIM.
- REQ-011 In OCIOSO, SHALL load somaTime into ultimo and the shift register, clear the BCD accumulator and iteration counter, and enter CONVERTE, when somaTime != ultimo; otherwise remain in OCIOSO.
- REQ-012 In CONVERTE, each cycle SHALL add 3 to every accumulator nibble >= 5, then shift {accumulator, shift register} left one bit; after exactly 7 iterations SHALL enter FIM.
- REQ-013 In FIM, SHALL copy the accumulator to bcd, assert pronto for that one cycle, and return to OCIOSO.
- REQ-014 Latency: with a change sampled at edge k, bcd and pronto SHALL update at edge k+8.
- REQ-015 Changes of somaTime while in CONVERTE or FIM SHALL be ignored for the conversion in progress.
- REQ-016 After FIM, OCIOSO SHALL re-compare, so a value that changed mid-conversion starts a new conversion on the first OCIOSO cycle.
- REQ-017 bcd SHALL hold between conversions; hundreds SHALL never exceed 1.
- REQ-018 SHALL keep a scan counter 0..SCAN_DIV-1; on wrap, the digit index SHALL advance 0->1->2->0.
- REQ-019 an SHALL be one-hot active-low for the current index: 3'b110, 3'b101, 3'b011.
- REQ-020 seg SHALL be the registered-bcd digit for the current index through the 7-segment decoder (0 = 7'b1000000, 1 = 7'b1111001, 7 = 7'b1111000, 9 = 7'b0010000).
- REQ-021 Leading-zero blanking: the hundreds digit SHALL be blank when zero; the tens digit SHALL be blank when hundreds and tens are both zero; the units digit SHALL never be blank; blank = 7'b1111111.
- REQ-022 The scan SHALL be independent of conversion; a pronto SHALL change seg on the next cycle without resetting the scan.

Reset
- REQ-023 While clr=0, SHALL force: state OCIOSO, ultimo=0, accumulator=0, bcd=0, pronto=0, scan counter=0, index=0, an=3'b110, seg=7'b1000000.
- REQ-024 clr asserted mid-conversion SHALL abort it with no pronto; after release, a nonzero somaTime SHALL start a fresh conversion on the first cycle.

Structure
- REQ-025 SHALL place the segment pattern constants, blank pattern, FSM state encodings, and the iteration count (7) in shared package placar_pkg.
- REQ-026 SHALL implement the BCD-to-7-segment lookup as sub-module decod_7seg (4-bit input, 7-bit active-low output; codes 10-15 blank).

Verification
- REQ-027 Release reset with somaTime=0 -> no pronto; an=3'b110, seg=7'b1000000; tens and hundreds blank as they are scanned.
- REQ-028 Set somaTime=127 at edge k -> pronto high only at edge k+8, bcd=12'h127; scan shows 1, 2, 7.
- REQ-029 Set somaTime=5 -> bcd=12'h005; hundreds and tens show 7'b1111111; units shows 7'b0010010.
- REQ-030 Set 45, then 99 three cycles later -> pronto with bcd=12'h045, then a second pronto with bcd=12'h099 exactly 9 cycles after the first.
- REQ-031 Set 88, assert clr at the 4th CONVERTE cycle, release with 88 held -> no pronto during reset; bcd=0 during reset; a pronto with bcd=12'h088 8 cycles after release.
- REQ-032 SCAN_DIV=4 -> an sequence 110,101,011,110, each held exactly 4 cycles.

Source files
------------

// File: rtl/placar_pkg.sv
// rtl/placar_pkg.sv - shared constants, FSM encoding and helpers for the score display
package placar_pkg;

  // Conversion FSM: idle/compare, shift-add iterations, publish result
  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    FIM      = 2'd2
  } estadoT;

  // One shift-add iteration per bit of the 7-bit score
  localparam int ITERACOES = 7;

  // Active-low segment patterns, bit 0 = a ... bit 6 = g
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low digit enables, indexed by scan position
  localparam logic [2:0] AN_UNIDADE = 3'b110;
  localparam logic [2:0] AN_DEZENA  = 3'b101;
  localparam logic [2:0] AN_CENTENA = 3'b011;

  // Double-dabble correction: add 3 to every nibble that is 5 or more
  function automatic logic [11:0] ajustaBcd(input logic [11:0] acc);
    logic [11:0] res;
    res = acc;
    for (int i = 0; i < 3; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

  // Digit enable pattern for a scan index (0 units, 1 tens, 2 hundreds)
  function automatic logic [2:0] anPara(input logic [1:0] indice);
    logic [2:0] res;
    case (indice)
      2'd0:    res = AN_UNIDADE;
      2'd1:    res = AN_DEZENA;
      2'd2:    res = AN_CENTENA;
      default: res = AN_UNIDADE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/decod_7seg.sv
// rtl/decod_7seg.sv - BCD digit to active-low 7-segment pattern
module decod_7seg
  import placar_pkg::*;
(
  input  logic [3:0] digito,
  output logic [6:0] segmentos
);

  // Pure lookup; codes above 9 are not valid BCD and show nothing
  always_comb begin
    segmentos = SEG_BLANK;
    case (digito)
      4'd0:    segmentos = SEG_0;
      4'd1:    segmentos = SEG_1;
      4'd2:    segmentos = SEG_2;
      4'd3:    segmentos = SEG_3;
      4'd4:    segmentos = SEG_4;
      4'd5:    segmentos = SEG_5;
      4'd6:    segmentos = SEG_6;
      4'd7:    segmentos = SEG_7;
      4'd8:    segmentos = SEG_8;
      4'd9:    segmentos = SEG_9;
      default: segmentos = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_placar.sv
// rtl/display_placar.sv - score to BCD conversion and 3-digit multiplexed display
module display_placar
  import placar_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clock,
  input  logic        clr,
  input  logic [6:0]  somaTime,
  output logic [11:0] bcd,
  output logic        pronto,
  output logic [2:0]  an,
  output logic [6:0]  seg
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SCAN_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [2:0] ULTIMA_ITER = 3'(ITERACOES - 1);

  // Conversion state
  estadoT      estado;
  logic [6:0]  ultimo;
  logic [6:0]  desloc;
  logic [11:0] acum;
  logic [11:0] acumAjust;
  logic [2:0]  iter;

  // Scan state
  logic [CNT_W-1:0] scanCnt;
  logic [1:0]       indice;
  logic [1:0]       proxIndice;
  logic [3:0]       digito;
  logic [6:0]       segDecod;
  logic [6:0]       segProx;
  logic             apagar;

  assign acumAjust = ajustaBcd(acum);

  // Conversion FSM: detect a new score, run 7 shift-add steps, publish to bcd
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      estado <= OCIOSO;
      ultimo <= '0;
      desloc <= '0;
      acum   <= '0;
      iter   <= '0;
      bcd    <= '0;
      pronto <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (somaTime != ultimo) begin
            ultimo <= somaTime;
            desloc <= somaTime;
            acum   <= '0;
            iter   <= '0;
            estado <= CONVERTE;
          end
        end
        CONVERTE: begin
          {acum, desloc} <= {acumAjust, desloc} << 1;
          iter           <= iter + 3'd1;
          if (iter == ULTIMA_ITER) begin
            estado <= FIM;
          end
        end
        FIM: begin
          bcd    <= acum;
          pronto <= 1'b1;
          estado <= OCIOSO;
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

  // Next scan position: advance only when the per-digit dwell counter wraps
  always_comb begin
    proxIndice = indice;
    if (scanCnt == SCAN_MAX) begin
      case (indice)
        2'd0:    proxIndice = 2'd1;
        2'd1:    proxIndice = 2'd2;
        default: proxIndice = 2'd0;
      endcase
    end
  end

  // Pick the digit for the upcoming scan position and decide leading-zero blanking
  always_comb begin
    digito = bcd[3:0];
    apagar = 1'b0;
    case (proxIndice)
      2'd1: begin
        digito = bcd[7:4];
        apagar = (bcd[11:4] == 8'd0);
      end
      2'd2: begin
        digito = bcd[11:8];
        apagar = (bcd[11:8] == 4'd0);
      end
      default: begin
        digito = bcd[3:0];
        apagar = 1'b0;
      end
    endcase
  end

  decod_7seg uDecod (
    .digito    (digito),
    .segmentos (segDecod)
  );

  assign segProx = apagar ? SEG_BLANK : segDecod;

  // Scan counter, digit index and registered an/seg; runs independently of the FSM
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      scanCnt <= '0;
      indice  <= 2'd0;
      an      <= AN_UNIDADE;
      seg     <= SEG_0;
    end else begin
      if (scanCnt == SCAN_MAX) begin
        scanCnt <= '0;
      end else begin
        scanCnt <= scanCnt + 1'b1;
      end
      indice <= proxIndice;
      an     <= anPara(proxIndice);
      seg    <= segProx;
    end
  end

endmodule

// File: tb/tb_display_placar.sv
// tb/tb_display_placar.sv - self-checking bench for display_placar
module tb_display_placar;

  logic        clock = 1'b0;
  logic        clr = 1'b0;
  logic [6:0]  somaTime = 7'd0;
  logic [11:0] bcd;
  logic        pronto;
  logic [2:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;
  int cycleNum = 0;

  logic [11:0] expBcdQ[$];
  int          expCycQ[$];
  logic [2:0]  anLog[$];
  logic [6:0]  segLog[$];
  logic        prontoLog[$];

  display_placar #(.SCAN_DIV(4)) dut (
    .clock    (clock),
    .clr      (clr),
    .somaTime (somaTime),
    .bcd      (bcd),
    .pronto   (pronto),
    .an       (an),
    .seg      (seg)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleNum <= cycleNum + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] bcdOf(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [6:0] segTab(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] expSeg(input logic [11:0] b, input logic [2:0] anV);
    case (anV)
      3'b110: return segTab(b[3:0]);
      3'b101: return (b[11:4] == 8'd0) ? 7'b1111111 : segTab(b[7:4]);
      3'b011: return (b[11:8] == 4'd0) ? 7'b1111111 : segTab(b[11:8]);
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  function automatic logic [2:0] nextAn(input logic [2:0] a);
    case (a)
      3'b110: return 3'b101;
      3'b101: return 3'b011;
      default: return 3'b110;
    endcase
  endfunction

  task automatic waitPronto(input int limit, output bit seen, output int cyc);
    seen = 1'b0;
    cyc = -1;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clock);
      if (pronto === 1'b1) begin
        seen = 1'b1;
        cyc = cycleNum;
      end
    end
  endtask

  task automatic sampleScan(input int n);
    anLog.delete();
    segLog.delete();
    prontoLog.delete();
    repeat (n) begin
      @(negedge clock);
      anLog.push_back(an);
      segLog.push_back(seg);
      prontoLog.push_back(pronto);
    end
  endtask

  task automatic test_reset();
    bit sawTens, sawHund;
    clr = 1'b0;
    somaTime = 7'd0;
    repeat (3) @(negedge clock);
    checks++; if (an !== 3'b110) begin errors++; $display("FAIL reset_an: got %b expected 110", an); end
    checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg: got %b expected 1000000", seg); end
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd: got %h expected 000", bcd); end
    checks++; if (pronto !== 1'b0) begin errors++; $display("FAIL reset_pronto: got %b expected 0", pronto); end
    clr = 1'b1;
    sampleScan(16);
    sawTens = 0;
    sawHund = 0;
    for (int i = 0; i < anLog.size(); i++) begin
      if (anLog[i] === 3'b101) sawTens = 1;
      if (anLog[i] === 3'b011) sawHund = 1;
      checks++; if (prontoLog[i] !== 1'b0) begin errors++; $display("FAIL zero_no_pronto[%0d]: got %b expected 0", i, prontoLog[i]); end
      checks++; if (segLog[i] !== expSeg(12'h000, anLog[i])) begin errors++; $display("FAIL zero_seg[%0d]: an %b got %b expected %b", i, anLog[i], segLog[i], expSeg(12'h000, anLog[i])); end
    end
    checks++; if (!(sawTens && sawHund)) begin errors++; $display("FAIL zero_scan_cover: tens %0b hundreds %0b expected both 1", sawTens, sawHund); end
  endtask

  task automatic test_scan();
    logic [2:0] cur;
    int len;
    int guard;
    cur = an;
    guard = 0;
    while (an === cur && guard < 20) begin @(negedge clock); guard++; end
    checks++; if (guard >= 20) begin errors++; $display("FAIL scan_start: an stuck at %b, expected a change within 20 cycles", cur); end
    for (int r = 0; r < 4; r++) begin
      cur = an;
      len = 0;
      while (an === cur && len < 20) begin @(negedge clock); len++; end
      checks++; if (len !== 4) begin errors++; $display("FAIL scan_dwell[%0d]: an %b held %0d cycles expected 4", r, cur, len); end
      checks++; if (an !== nextAn(cur)) begin errors++; $display("FAIL scan_order[%0d]: after %b got %b expected %b", r, cur, an, nextAn(cur)); end
    end
  endtask

  task automatic runConversion(input string nome, input int v, input int limit);
    bit seen;
    int cyc;
    logic [11:0] eb;
    int ec;
    @(negedge clock);
    somaTime = 7'(v);
    expBcdQ.push_back(bcdOf(v));
    expCycQ.push_back(cycleNum + 9);
    waitPronto(limit, seen, cyc);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: no pronto within %0d cycles", nome, limit);
      void'(expBcdQ.pop_front());
      void'(expCycQ.pop_front());
    end else begin
      eb = expBcdQ.pop_front();
      ec = expCycQ.pop_front();
      if (bcd !== eb) begin errors++; $display("FAIL %s_bcd: got %h expected %h", nome, bcd, eb); end
      checks++; if (cyc !== ec) begin errors++; $display("FAIL %s_latency: pronto at cycle %0d expected %0d", nome, cyc, ec); end
      @(negedge clock);
      checks++; if (pronto !== 1'b0) begin errors++; $display("FAIL %s_pulse: pronto %b one cycle later expected 0", nome, pronto); end
    end
  endtask

  task automatic test_max();
    bit sawAll[3];
    runConversion("max127", 127, 30);
    sampleScan(12);
    sawAll = '{0, 0, 0};
    for (int i = 0; i < anLog.size(); i++) begin
      if (anLog[i] === 3'b110 && segLog[i] === 7'b1111000) sawAll[0] = 1;
      if (anLog[i] === 3'b101 && segLog[i] === 7'b0100100) sawAll[1] = 1;
      if (anLog[i] === 3'b011 && segLog[i] === 7'b1111001) sawAll[2] = 1;
      checks++; if (segLog[i] !== expSeg(12'h127, anLog[i])) begin errors++; $display("FAIL max_seg[%0d]: an %b got %b expected %b", i, anLog[i], segLog[i], expSeg(12'h127, anLog[i])); end
    end
    checks++; if (!(sawAll[0] && sawAll[1] && sawAll[2])) begin errors++; $display("FAIL max_digits_shown: units %0b tens %0b hundreds %0b expected all 1", sawAll[0], sawAll[1], sawAll[2]); end
  endtask

  task automatic test_small();
    runConversion("small5", 5, 30);
    sampleScan(12);
    for (int i = 0; i < anLog.size(); i++) begin
      checks++; if (segLog[i] !== expSeg(12'h005, anLog[i])) begin errors++; $display("FAIL small_seg[%0d]: an %b got %b expected %b", i, anLog[i], segLog[i], expSeg(12'h005, anLog[i])); end
      if (anLog[i] === 3'b110) begin
        checks++; if (segLog[i] !== 7'b0010010) begin errors++; $display("FAIL small_units[%0d]: got %b expected 0010010", i, segLog[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int cyc;
    int first;
    logic [11:0] eb;
    int ec;
    @(negedge clock);
    somaTime = 7'd45;
    expBcdQ.push_back(12'h045);
    expCycQ.push_back(cycleNum + 9);
    repeat (3) @(negedge clock);
    somaTime = 7'd99;
    waitPronto(30, seen, cyc);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL b2b_first_timeout: no pronto within 30 cycles");
      void'(expBcdQ.pop_front());
      void'(expCycQ.pop_front());
      first = cycleNum;
    end else begin
      eb = expBcdQ.pop_front();
      ec = expCycQ.pop_front();
      if (bcd !== eb) begin errors++; $display("FAIL b2b_first_bcd: got %h expected %h", bcd, eb); end
      checks++; if (cyc !== ec) begin errors++; $display("FAIL b2b_first_latency: pronto at cycle %0d expected %0d", cyc, ec); end
      first = cyc;
    end
    expBcdQ.push_back(12'h099);
    expCycQ.push_back(first + 9);
    waitPronto(30, seen, cyc);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL b2b_second_timeout: no pronto within 30 cycles");
      void'(expBcdQ.pop_front());
      void'(expCycQ.pop_front());
    end else begin
      eb = expBcdQ.pop_front();
      ec = expCycQ.pop_front();
      if (bcd !== eb) begin errors++; $display("FAIL b2b_second_bcd: got %h expected %h", bcd, eb); end
      checks++; if (cyc !== ec) begin errors++; $display("FAIL b2b_second_gap: pronto at cycle %0d expected %0d", cyc, ec); end
    end
    sampleScan(10);
    for (int i = 0; i < prontoLog.size(); i++) begin
      checks++; if (prontoLog[i] !== 1'b0) begin errors++; $display("FAIL hold_no_pronto[%0d]: got %b expected 0", i, prontoLog[i]); end
    end
    checks++; if (bcd !== 12'h099) begin errors++; $display("FAIL hold_bcd: got %h expected 099", bcd); end
  endtask

  task automatic test_reset_abort();
    bit seen;
    int cyc;
    logic [11:0] eb;
    int ec;
    @(negedge clock);
    somaTime = 7'd88;
    repeat (4) @(negedge clock);
    clr = 1'b0;
    repeat (4) begin
      @(negedge clock);
      checks++; if (pronto !== 1'b0) begin errors++; $display("FAIL abort_pronto: got %b during reset expected 0", pronto); end
      checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL abort_bcd: got %h during reset expected 000", bcd); end
    end
    clr = 1'b1;
    expBcdQ.push_back(12'h088);
    expCycQ.push_back(cycleNum + 9);
    waitPronto(30, seen, cyc);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL abort_restart_timeout: no pronto within 30 cycles");
      void'(expBcdQ.pop_front());
      void'(expCycQ.pop_front());
    end else begin
      eb = expBcdQ.pop_front();
      ec = expCycQ.pop_front();
      if (bcd !== eb) begin errors++; $display("FAIL abort_restart_bcd: got %h expected %h", bcd, eb); end
      checks++; if (cyc !== ec) begin errors++; $display("FAIL abort_restart_latency: pronto at cycle %0d expected %0d", cyc, ec); end
    end
  endtask

  task automatic test_random();
    int prev;
    int v;
    prev = 88;
    for (int n = 0; n < 8; n++) begin
      v = $urandom_range(1, 127);
      if (v == prev) v = (v == 127) ? 1 : v + 1;
      runConversion("random", v, 30);
      prev = v;
    end
    runConversion("edge100", (prev == 100) ? 10 : 100, 30);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_max();
    test_small();
    test_back_to_back();
    test_reset_abort();
    test_random();
    checks++;
    if (expBcdQ.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left expected 0", expBcdQ.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
